mem_axi_master: RTL and testbench



---
 rtl/mem_axi_master.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_axi_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_master.sv
// Core/cache memory port to AXI4-Lite bridge: turns level-held ren/wen requests
// into single AXI4-Lite transactions and returns a one-cycle completion pulse.
module mem_axi_master #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   // requester read port
   input  logic                      ren,
   input  logic [ADDR_WIDTH-1:0]     raddr,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic                      rvalid,
   // requester write port
   input  logic                      wen,
   input  logic [ADDR_WIDTH-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wmask,
   output logic                      wvalid,
   // AW channel
   output logic [ADDR_WIDTH-1:0]     awaddr,
   output logic                      awvalid,
   input  logic                      awready,
   // W channel
   output logic [DATA_WIDTH-1:0]     axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   wstrb,
   output logic                      axi_wvalid,
   input  logic                      wready,
   // B channel
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   // AR channel
   output logic [ADDR_WIDTH-1:0]     araddr,
   output logic                      arvalid,
   input  logic                      arready,
   // R channel
   input  logic [DATA_WIDTH-1:0]     axi_rdata,
   input  logic [1:0]                rresp,
   input  logic                      axi_rvalid,
   output logic                      rready,
   // status
   output logic                      bus_err,
   output logic [2:0]                debug_state
);

   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WADDR = 3'd1,
      S_WRESP = 3'd2,
      S_RADDR = 3'd3,
      S_RDATA = 3'd4,
      S_DONE  = 3'd5,
      S_DRAIN = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  awvalid_q, awvalid_d;
   logic                  axi_wvalid_q, axi_wvalid_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  bready_q, bready_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bus_err_q, bus_err_d;
   logic                  served_write_q, served_write_d;

   logic aw_hs, w_hs, aw_now, w_now;

   assign aw_hs  = awvalid_q & awready;
   assign w_hs   = axi_wvalid_q & wready;
   assign aw_now = aw_done_q | aw_hs;
   assign w_now  = w_done_q | w_hs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         awaddr_q       <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         awvalid_q      <= 1'b0;
         axi_wvalid_q   <= 1'b0;
         aw_done_q      <= 1'b0;
         w_done_q       <= 1'b0;
         bready_q       <= 1'b0;
         araddr_q       <= '0;
         arvalid_q      <= 1'b0;
         rready_q       <= 1'b0;
         rdata_q        <= '0;
         rvalid_q       <= 1'b0;
         wvalid_q       <= 1'b0;
         bus_err_q      <= 1'b0;
         served_write_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         awaddr_q       <= awaddr_d;
         wdata_q        <= wdata_d;
         wstrb_q        <= wstrb_d;
         awvalid_q      <= awvalid_d;
         axi_wvalid_q   <= axi_wvalid_d;
         aw_done_q      <= aw_done_d;
         w_done_q       <= w_done_d;
         bready_q       <= bready_d;
         araddr_q       <= araddr_d;
         arvalid_q      <= arvalid_d;
         rready_q       <= rready_d;
         rdata_q        <= rdata_d;
         rvalid_q       <= rvalid_d;
         wvalid_q       <= wvalid_d;
         bus_err_q      <= bus_err_d;
         served_write_q <= served_write_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      awaddr_d       = awaddr_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      awvalid_d      = awvalid_q;
      axi_wvalid_d   = axi_wvalid_q;
      aw_done_d      = aw_done_q;
      w_done_d       = w_done_q;
      bready_d       = bready_q;
      araddr_d       = araddr_q;
      arvalid_d      = arvalid_q;
      rready_d       = rready_q;
      rdata_d        = rdata_q;
      rvalid_d       = rvalid_q;
      wvalid_d       = wvalid_q;
      bus_err_d      = bus_err_q;
      served_write_d = served_write_q;

      unique case (state_q)
         S_IDLE: begin
            // a simultaneous write and read request is resolved in favour of the write
            if (wen) begin
               awaddr_d       = waddr;
               wdata_d        = wdata;
               wstrb_d        = wmask;
               awvalid_d      = 1'b1;
               axi_wvalid_d   = 1'b1;
               aw_done_d      = 1'b0;
               w_done_d       = 1'b0;
               served_write_d = 1'b1;
               state_d        = S_WADDR;
            end else if (ren) begin
               araddr_d       = raddr;
               arvalid_d      = 1'b1;
               served_write_d = 1'b0;
               state_d        = S_RADDR;
            end
         end
         S_WADDR: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  axi_wvalid_d = 1'b0;
            aw_done_d = aw_now;
            w_done_d  = w_now;
            if (aw_now && w_now) begin
               bready_d = 1'b1;
               state_d  = S_WRESP;
            end
         end
         S_WRESP: begin
            if (bvalid && bready_q) begin
               bready_d = 1'b0;
               wvalid_d = 1'b1;
               if (bresp != 2'b00) bus_err_d = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_RADDR: begin
            if (arvalid_q && arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RDATA;
            end
         end
         S_RDATA: begin
            // error responses still deliver their data to the requester
            if (axi_rvalid && rready_q) begin
               rdata_d  = axi_rdata;
               rready_d = 1'b0;
               rvalid_d = 1'b1;
               if (rresp != 2'b00) bus_err_d = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            rvalid_d = 1'b0;
            wvalid_d = 1'b0;
            state_d  = S_DRAIN;
         end
         S_DRAIN: begin
            // hold off until the requester has dropped the line we just served
            if (served_write_q ? !wen : !ren) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign awaddr      = awaddr_q;
   assign awvalid     = awvalid_q;
   assign axi_wdata   = wdata_q;
   assign wstrb       = wstrb_q;
   assign axi_wvalid  = axi_wvalid_q;
   assign bready      = bready_q;
   assign araddr      = araddr_q;
   assign arvalid     = arvalid_q;
   assign rready      = rready_q;
   assign rdata       = rdata_q;
   assign rvalid      = rvalid_q;
   assign wvalid      = wvalid_q;
   assign bus_err     = bus_err_q;
   assign debug_state = state_q;

endmodule

// File: tb/tb_mem_axi_master.sv
// Self-checking bench for mem_axi_master: a reactive AXI4-Lite slave plus a
// scoreboard of expected AW/W/AR beats and read data.
module tb_mem_axi_master;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int SW = DW / 8;
   localparam int TIMEOUT = 200;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ren = 1'b0;
   logic [AW-1:0] raddr = '0;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          wen = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [DW-1:0] wdata = '0;
   logic [SW-1:0] wmask = '0;
   logic          wvalid;
   logic [AW-1:0] awaddr;
   logic          awvalid;
   logic          awready = 1'b0;
   logic [DW-1:0] axi_wdata;
   logic [SW-1:0] wstrb;
   logic          axi_wvalid;
   logic          wready = 1'b0;
   logic [1:0]    bresp = 2'b00;
   logic          bvalid = 1'b0;
   logic          bready;
   logic [AW-1:0] araddr;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [DW-1:0] axi_rdata = '0;
   logic [1:0]    rresp = 2'b00;
   logic          axi_rvalid = 1'b0;
   logic          rready;
   logic          bus_err;
   logic [2:0]    debug_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [AW-1:0]    exp_aw[$];
   logic [DW+SW-1:0] exp_w[$];
   logic [AW-1:0]    exp_ar[$];
   logic [DW-1:0]    exp_rd[$];

   always #5 clk = ~clk;

   mem_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
      .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask), .wvalid(wvalid),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .axi_wdata(axi_wdata), .wstrb(wstrb), .axi_wvalid(axi_wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .axi_rdata(axi_rdata), .rresp(rresp), .axi_rvalid(axi_rvalid), .rready(rready),
      .bus_err(bus_err), .debug_state(debug_state)
   );

   // Requester plus reactive slave for one request (or a simultaneous write+read pair).
   // Ready/valid decisions are made on the falling edge and take effect at the next rising edge.
   task automatic run_txn(input bit do_w, input bit do_r,
                          input logic [AW-1:0] w_a, input logic [DW-1:0] w_d, input logic [SW-1:0] w_m,
                          input logic [AW-1:0] r_a, input logic [DW-1:0] r_d,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input int ar_dly, input int r_dly,
                          input logic [1:0] b_rsp, input logic [1:0] r_rsp);
      int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
      int wp = 0, rp = 0, settle = 0;
      int first_ar = -1, wpulse_cyc = -1;
      bit aw_seen = 0, w_seen = 0, ar_seen = 0;
      bit aw_hs = 0, w_hs = 0, ar_hs = 0, finished = 0;
      logic [AW-1:0]    ea;
      logic [DW+SW-1:0] ew;
      logic [DW-1:0]    ed;
      @(negedge clk);
      if (do_w) begin
         wen = 1'b1; waddr = w_a; wdata = w_d; wmask = w_m;
         exp_aw.push_back(w_a);
         exp_w.push_back({w_d, w_m});
      end
      if (do_r) begin
         ren = 1'b1; raddr = r_a;
         exp_ar.push_back(r_a);
         exp_rd.push_back(r_d);
      end
      for (int cyc = 0; cyc < TIMEOUT && !finished; cyc++) begin
         @(negedge clk);
         // completion pulses
         if (wvalid) begin
            wp++; wen = 1'b0; wpulse_cyc = cyc;
         end
         if (rvalid) begin
            rp++; ren = 1'b0;
            n_checks++;
            ed = (exp_rd.size() > 0) ? exp_rd.pop_front() : 'x;
            if (rdata !== ed) begin
               n_fail++; $display("FAIL rdata: got %h expected %h", rdata, ed);
            end
         end
         // AW channel
         if (awvalid) aw_seen = 1'b1;
         if (awready) begin
            awready = 1'b0; aw_hs = 1'b1;
            n_checks++;
            if (awvalid !== 1'b0) begin
               n_fail++; $display("FAIL awvalid_drop: got %b expected 0", awvalid);
            end
         end else if (awvalid) begin
            if (aw_cnt == aw_dly) begin
               n_checks++;
               ea = (exp_aw.size() > 0) ? exp_aw.pop_front() : 'x;
               if (awaddr !== ea) begin
                  n_fail++; $display("FAIL awaddr: got %h expected %h", awaddr, ea);
               end
               awready = 1'b1;
            end else aw_cnt++;
         end else if (aw_seen && !aw_hs) begin
            n_checks++; n_fail++;
            $display("FAIL awvalid_hold: got 0 expected 1 before awready");
         end
         // W channel
         if (axi_wvalid) w_seen = 1'b1;
         if (wready) begin
            wready = 1'b0; w_hs = 1'b1;
            n_checks++;
            if (axi_wvalid !== 1'b0) begin
               n_fail++; $display("FAIL wvalid_drop: got %b expected 0", axi_wvalid);
            end
         end else if (axi_wvalid) begin
            if (w_cnt == w_dly) begin
               n_checks++;
               ew = (exp_w.size() > 0) ? exp_w.pop_front() : 'x;
               if ({axi_wdata, wstrb} !== ew) begin
                  n_fail++; $display("FAIL wdata_wstrb: got %h/%h expected %h", axi_wdata, wstrb, ew);
               end
               wready = 1'b1;
            end else w_cnt++;
         end else if (w_seen && !w_hs) begin
            n_checks++; n_fail++;
            $display("FAIL axi_wvalid_hold: got 0 expected 1 before wready");
         end
         // B channel
         if (bready) begin
            n_checks++;
            if (debug_state !== 3'd2) begin
               n_fail++; $display("FAIL bready_state: got state %0d expected 2", debug_state);
            end
         end
         if (bvalid) bvalid = 1'b0;
         else if (bready) begin
            if (b_cnt == b_dly) begin bvalid = 1'b1; bresp = b_rsp; end
            else b_cnt++;
         end
         // AR channel
         if (arvalid) begin
            ar_seen = 1'b1;
            if (first_ar < 0) first_ar = cyc;
         end
         if (arready) begin
            arready = 1'b0; ar_hs = 1'b1;
            n_checks++;
            if (arvalid !== 1'b0) begin
               n_fail++; $display("FAIL arvalid_drop: got %b expected 0", arvalid);
            end
         end else if (arvalid) begin
            if (ar_cnt == ar_dly) begin
               n_checks++;
               ea = (exp_ar.size() > 0) ? exp_ar.pop_front() : 'x;
               if (araddr !== ea) begin
                  n_fail++; $display("FAIL araddr: got %h expected %h", araddr, ea);
               end
               arready = 1'b1;
            end else ar_cnt++;
         end else if (ar_seen && !ar_hs) begin
            n_checks++; n_fail++;
            $display("FAIL arvalid_hold: got 0 expected 1 before arready");
         end
         // R channel
         if (rready) begin
            n_checks++;
            if (debug_state !== 3'd4) begin
               n_fail++; $display("FAIL rready_state: got state %0d expected 4", debug_state);
            end
         end
         if (axi_rvalid) axi_rvalid = 1'b0;
         else if (rready) begin
            if (r_cnt == r_dly) begin axi_rvalid = 1'b1; axi_rdata = r_d; rresp = r_rsp; end
            else r_cnt++;
         end
         // a few idle cycles after completion catch stray pulses or re-issue
         if ((!do_w || wp > 0) && (!do_r || rp > 0) && debug_state == 3'd0) begin
            settle++;
            if (settle == 3) finished = 1'b1;
         end
      end
      n_checks++;
      if (!finished) begin
         n_fail++; $display("FAIL txn_timeout: got state %0d expected completion within %0d cycles", debug_state, TIMEOUT);
         wen = 1'b0; ren = 1'b0;
      end
      n_checks++;
      if (wp != int'(do_w)) begin
         n_fail++; $display("FAIL wvalid_pulses: got %0d expected %0d", wp, int'(do_w));
      end
      n_checks++;
      if (rp != int'(do_r)) begin
         n_fail++; $display("FAIL rvalid_pulses: got %0d expected %0d", rp, int'(do_r));
      end
      if (do_w && do_r) begin
         n_checks++;
         if (!(first_ar > wpulse_cyc && wpulse_cyc >= 0)) begin
            n_fail++; $display("FAIL write_first: got arvalid at %0d wvalid at %0d expected arvalid later", first_ar, wpulse_cyc);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({awvalid, axi_wvalid, bready, arvalid, rready, rvalid, wvalid, bus_err} !== 8'h00) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 00000000",
            {awvalid, axi_wvalid, bready, arvalid, rready, rvalid, wvalid, bus_err});
      end
      n_checks++;
      if ((awaddr | araddr | axi_wdata | rdata) !== '0 || wstrb !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h %h %h %h %h expected all 0", awaddr, araddr, axi_wdata, rdata, wstrb);
      end
      n_checks++;
      if (debug_state !== 3'd0) begin
         n_fail++; $display("FAIL reset_state: got %0d expected 0", debug_state);
      end
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_write();
      run_txn(1, 0, 64'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF, '0, '0, 2, 2, 1, 0, 0, 2'b00, 2'b00);
      n_checks++;
      if (bus_err !== 1'b0) begin
         n_fail++; $display("FAIL write_bus_err: got %b expected 0", bus_err);
      end
      $display("test_write done: addr=100");
   endtask

   task automatic test_read();
      run_txn(0, 1, '0, '0, '0, 64'h100, 64'h1234, 0, 0, 0, 0, 3, 2'b00, 2'b00);
      repeat (10) @(negedge clk);
      n_checks++;
      if (rdata !== 64'h1234) begin
         n_fail++; $display("FAIL rdata_hold: got %h expected 1234", rdata);
      end
      $display("test_read done: addr=100 data=%h", rdata);
   endtask

   task automatic test_simultaneous();
      run_txn(1, 1, 64'h200, 64'h0123_4567_89AB_CDEF, 8'h0F, 64'h300, 64'hABCD, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      n_checks++;
      if (rdata !== 64'hABCD) begin
         n_fail++; $display("FAIL simul_rdata: got %h expected abcd", rdata);
      end
      $display("test_simultaneous done");
   endtask

   task automatic test_aw_before_w();
      run_txn(1, 0, 64'h440, 64'h5555_AAAA_5555_AAAA, 8'hC3, '0, '0, 0, 3, 0, 0, 0, 2'b00, 2'b00);
      $display("test_aw_before_w done");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         a = {32'h0, $urandom} & 64'hFFF8;
         d = {$urandom, $urandom};
         if (i % 2 == 0)
            run_txn(1, 0, a, d, 8'($urandom), '0, '0,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 2'b00, 2'b00);
         else
            run_txn(0, 1, '0, '0, '0, a, d, 0, 0, 0,
                    $urandom_range(0, 3), $urandom_range(0, 3), 2'b00, 2'b00);
         $display("test_back_to_back txn %0d: %s addr=%h data=%h", i, (i % 2 == 0) ? "write" : "read", a, d);
      end
   endtask

   task automatic test_bus_err();
      run_txn(0, 1, '0, '0, '0, 64'h800, 64'hBAD0, 0, 0, 0, 1, 0, 2'b00, 2'b10);
      n_checks++;
      if (bus_err !== 1'b1) begin
         n_fail++; $display("FAIL bus_err_set: got %b expected 1", bus_err);
      end
      run_txn(1, 0, 64'h808, 64'h1, 8'h01, '0, '0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      n_checks++;
      if (bus_err !== 1'b1) begin
         n_fail++; $display("FAIL bus_err_sticky: got %b expected 1", bus_err);
      end
      $display("test_bus_err done: bus_err=%b", bus_err);
   endtask

   task automatic test_reset_mid(input bit is_write);
      logic [2:0] target;
      bit reached = 0;
      int pulses = 0;
      target = is_write ? 3'd2 : 3'd4;
      @(negedge clk);
      if (is_write) begin
         wen = 1'b1; waddr = 64'h900; wdata = 64'h77; wmask = 8'hFF;
         awready = 1'b1; wready = 1'b1;
      end else begin
         ren = 1'b1; raddr = 64'h910; arready = 1'b1;
      end
      for (int i = 0; i < 20 && !reached; i++) begin
         @(negedge clk);
         if (debug_state == target) reached = 1'b1;
      end
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      n_checks++;
      if (!reached) begin
         n_fail++; $display("FAIL reset_mid_reach: got state %0d expected %0d", debug_state, target);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({awvalid, axi_wvalid, bready, arvalid, rready, rvalid, wvalid} !== 7'h00) begin
         n_fail++; $display("FAIL reset_mid_valids: got %b expected 0000000",
            {awvalid, axi_wvalid, bready, arvalid, rready, rvalid, wvalid});
      end
      n_checks++;
      if (debug_state !== 3'd0 || bus_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_state: got state %0d bus_err %b expected 0 0", debug_state, bus_err);
      end
      wen = 1'b0; ren = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (wvalid || rvalid) pulses++;
      end
      n_checks++;
      if (pulses != 0 || debug_state !== 3'd0) begin
         n_fail++; $display("FAIL reset_mid_after: got %0d pulses state %0d expected 0 pulses state 0", pulses, debug_state);
      end
      $display("test_reset_mid done: %s", is_write ? "WRESP" : "RDATA");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_simultaneous();
      test_aw_before_w();
      test_back_to_back();
      test_bus_err();
      test_reset_mid(1'b1);
      test_reset_mid(1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
